// File: rtl/bank_pkg.sv
// Shared types for the memory bank controller.
// Bank width, FSM state encoding and request source.
package bank_pkg;

   localparam int BANK_W = 2;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_DRAIN,
      ST_WRITE,
      ST_SETTLE
   } state_e;

   typedef enum logic [1:0] {
      SRC_CPU,
      SRC_ENTER,
      SRC_EXIT
   } src_e;

endpackage

// File: rtl/bank_stack.sv
// Saved-bank LIFO used for interrupt nesting.
// Push and pop in the same cycle are never issued by the controller.
module bank_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] push_data_i,
   output logic [W-1:0] top_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_idx, rd_idx;

   assign wr_idx  = AW'(cnt_q);
   assign rd_idx  = AW'(cnt_q - CW'(1));
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign top_o   = mem_q[rd_idx];

   always_comb begin
      cnt_d = cnt_q;
      if (push_i && !full_o)
         cnt_d = cnt_q + CW'(1);
      else if (pop_i && !empty_o)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   always_ff @(posedge clk) begin
      if (push_i && !full_o)
         mem_q[wr_idx] <= push_data_i;
   end

endmodule

// File: rtl/memory_bank_controller.sv
// Sequences bank changes: drain accesses, one selector write, settle.
// Interrupted banks are saved on a LIFO and restored on return.
module memory_bank_controller #(
   parameter int                 BANK_W        = bank_pkg::BANK_W,
   parameter int                 STACK_DEPTH   = 4,
   parameter logic [BANK_W-1:0]  IRQ_BANK      = '0,
   parameter int                 SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic [BANK_W-1:0] cpu_bank,
   output logic              cpu_ack,
   input  logic              irq_enter,
   input  logic              irq_exit,
   input  logic              mem_busy,
   output logic              sel_write_en,
   output logic [BANK_W-1:0] sel_in_data,
   output logic [BANK_W-1:0] cur_bank,
   output logic              stall,
   output logic              stack_overflow,
   output logic              stack_underflow
);

   import bank_pkg::*;

   state_e            state_q, state_d;
   src_e              src_q, src_d;
   logic [BANK_W-1:0] target_q, target_d;
   logic [BANK_W-1:0] cur_q, cur_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              pend_en_q, pend_en_d;
   logic              pend_ex_q, pend_ex_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              ack_same_q, ack_same_d;

   logic              p_enter, p_exit;
   logic              take_en, take_ex;
   logic              push, pop, full, empty;
   logic [BANK_W-1:0] top;
   logic              we, stall_c, ack_c;
   logic [BANK_W-1:0] data_c;

   bank_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (BANK_W)
   ) u_stack (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .pop_i       (pop),
      .push_data_i (cur_q),
      .top_o       (top),
      .full_o      (full),
      .empty_o     (empty)
   );

   // A pulse arriving in the cycle it is serviced still counts.
   assign p_enter   = pend_en_q | irq_enter;
   assign p_exit    = pend_ex_q | irq_exit;
   assign pend_en_d = p_enter & ~take_en;
   assign pend_ex_d = p_exit & ~take_ex;

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      target_d   = target_q;
      cur_d      = cur_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      ack_same_d = 1'b0;
      take_en    = 1'b0;
      take_ex    = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      we         = 1'b0;
      data_c     = '0;
      stall_c    = 1'b1;
      ack_c      = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            we      = 1'b1;
            state_d = ST_IDLE;
         end
         ST_IDLE: begin
            stall_c = 1'b0;
            if (p_enter) begin
               take_en  = 1'b1;
               target_d = IRQ_BANK;
               src_d    = SRC_ENTER;
               state_d  = ST_DRAIN;
               if (full) ovf_d = 1'b1;
               else      push  = 1'b1;
            end else if (p_exit) begin
               take_ex = 1'b1;
               if (empty) begin
                  unf_d = 1'b1;
               end else begin
                  pop      = 1'b1;
                  target_d = top;
                  src_d    = SRC_EXIT;
                  state_d  = ST_DRAIN;
               end
            end else if (cpu_req && !ack_same_q) begin
               // ack_same_q masks the request still held during its ack.
               if (cpu_bank == cur_q) begin
                  ack_same_d = 1'b1;
               end else begin
                  target_d = cpu_bank;
                  src_d    = SRC_CPU;
                  state_d  = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (!mem_busy) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            we     = 1'b1;
            data_c = target_q;
            cur_d  = target_q;
            if (SETTLE_CYCLES == 0) begin
               state_d = ST_IDLE;
               ack_c   = (src_q == SRC_CPU);
            end else begin
               state_d = ST_SETTLE;
               cnt_d   = 3'(SETTLE_CYCLES - 1);
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               ack_c   = (src_q == SRC_CPU);
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_INIT;
         src_q      <= SRC_CPU;
         target_q   <= '0;
         cur_q      <= '0;
         cnt_q      <= '0;
         pend_en_q  <= 1'b0;
         pend_ex_q  <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         ack_same_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         target_q   <= target_d;
         cur_q      <= cur_d;
         cnt_q      <= cnt_d;
         pend_en_q  <= pend_en_d;
         pend_ex_q  <= pend_ex_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         ack_same_q <= ack_same_d;
      end
   end

   // INIT drives a write, so outputs are forced low while reset is held.
   assign sel_write_en    = we & ~reset;
   assign sel_in_data     = reset ? '0 : data_c;
   assign stall           = stall_c & ~reset;
   assign cpu_ack         = (ack_c | ack_same_q) & ~reset;
   assign cur_bank        = cur_q;
   assign stack_overflow  = ovf_q;
   assign stack_underflow = unf_q;

endmodule
